// File: rtl/shift_load_ctrl_pkg.sv
// Shared encodings and defaults for the shift-register load sequencer.
package shift_load_ctrl_pkg;
   localparam int DEF_WIDTH    = 10;
   localparam int DEF_TICK_DIV = 4;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SHIFT = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_CHECK = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE  = S_IDLE,
      ST_SHIFT = S_SHIFT,
      ST_WAIT  = S_WAIT,
      ST_CHECK = S_CHECK,
      ST_DONE  = S_DONE
   } state_t;
endpackage

// File: rtl/shift_pacer.sv
// Pace counter for the gap between shifts: reloads to TICK_DIV-1, counts down while enabled.
// expire is combinational and marks the final wait cycle; no backpressure.
module shift_pacer
   import shift_load_ctrl_pkg::*;
#(
   parameter int TICK_DIV = DEF_TICK_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic expire
);
   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= RELOAD;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   // A count of 1 (or a degenerate 0) means this is the last wait cycle.
   assign expire = en && (cnt <= CW'(1));
endmodule

// File: rtl/shift_load_ctrl.sv
// Bit-serial loader for a right-shifting register (LSB first) with readback check; done 3+(WIDTH-1)*TICK_DIV cycles after start.
// Manual shift path is passed through only while idle; start and manual input are ignored while busy.
module shift_load_ctrl
   import shift_load_ctrl_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int TICK_DIV = DEF_TICK_DIV
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
   input  logic             abort,
   input  logic             man_pulse,
   input  logic             man_bit,
   input  logic [WIDTH-1:0] q_fb,
   output logic             shift_en,
   output logic             shift_bit,
   output logic             busy,
   output logic             done,
   output logic             match
);
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] shadow;
   logic [WIDTH-1:0] shadow_sh;
   logic [CNT_W-1:0] bit_cnt;
   logic             busy_q;
   logic             done_q;
   logic             match_q;
   logic             pace_load;
   logic             pace_en;
   logic             pace_expire;

   assign pace_load = (state == ST_SHIFT);
   assign pace_en   = (state == ST_WAIT);

   shift_pacer #(.TICK_DIV(TICK_DIV)) u_pacer (
      .clk    (clk),
      .rst    (rst),
      .load   (pace_load),
      .en     (pace_en),
      .expire (pace_expire)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         shadow  <= '0;
         bit_cnt <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         match_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  shadow  <= data_in;
                  bit_cnt <= '0;
                  match_q <= 1'b0;
                  busy_q  <= 1'b1;
                  state   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (bit_cnt != LAST_BIT) begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
               // The shift in this cycle happens regardless of abort.
               if (abort) begin
                  busy_q <= 1'b0;
                  state  <= ST_IDLE;
               end else if (bit_cnt == LAST_BIT) begin
                  state <= ST_CHECK;
               end else if (TICK_DIV == 1) begin
                  state <= ST_SHIFT;
               end else begin
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (abort) begin
                  busy_q <= 1'b0;
                  state  <= ST_IDLE;
               end else if (pace_expire) begin
                  state <= ST_SHIFT;
               end
            end
            ST_CHECK: begin
               match_q <= (q_fb == shadow);
               done_q  <= 1'b1;
               state   <= ST_DONE;
            end
            ST_DONE: begin
               busy_q <= 1'b0;
               state  <= ST_IDLE;
            end
            default: begin
               busy_q <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

   assign shadow_sh = shadow >> bit_cnt;

   always_comb begin
      shift_en  = 1'b0;
      shift_bit = 1'b0;
      if (state == ST_IDLE) begin
         shift_en  = man_pulse;
         shift_bit = man_bit;
      end else if (state == ST_SHIFT) begin
         shift_en  = 1'b1;
         shift_bit = shadow_sh[0];
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign match = match_q;
endmodule

// File: tb/tb_shift_load_ctrl.sv
// Bench: two sequencers (default pace and TICK_DIV=1) each driving a 10-bit right-shift register fed back to q_fb.
module tb_shift_load_ctrl;
   logic clk;
   logic rst;

   logic       start0, abort0, man_pulse0, man_bit0;
   logic [9:0] data0, q0, qfb0;
   logic       shift_en0, shift_bit0, busy0, done0, match0;
   logic       stuck;

   logic       start1, abort1, man_pulse1, man_bit1;
   logic [9:0] data1, q1;
   logic       shift_en1, shift_bit1, busy1, done1, match1;

   int         n_cmp;
   int         n_bad;
   int         cur_rel;
   logic [9:0] mdl0;

   shift_load_ctrl dut0 (
      .clk(clk), .rst(rst), .start(start0), .data_in(data0), .abort(abort0),
      .man_pulse(man_pulse0), .man_bit(man_bit0), .q_fb(qfb0),
      .shift_en(shift_en0), .shift_bit(shift_bit0), .busy(busy0), .done(done0), .match(match0)
   );

   shift_load_ctrl #(.TICK_DIV(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .data_in(data1), .abort(abort1),
      .man_pulse(man_pulse1), .man_bit(man_bit1), .q_fb(q1),
      .shift_en(shift_en1), .shift_bit(shift_bit1), .busy(busy1), .done(done1), .match(match1)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) q0 <= '0;
      else if (shift_en0) q0 <= {shift_bit0, q0[9:1]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) q1 <= '0;
      else if (shift_en1) q1 <= {shift_bit1, q1[9:1]};
   end

   // Stuck-at-0 on bit 0 of the readback path only; the register itself is intact.
   assign qfb0 = stuck ? (q0 & 10'h3FE) : q0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cur_rel, obs, exp);
      end
   endtask

   // Cycle 0 is the cycle in which start is driven; expected shift/done cycles
   // are queued up front and popped as each cycle is observed.
   task automatic run_load(input bit sel, input logic [9:0] word, input int td,
                           input int abort_at, input bit noise, input bit busy_start,
                           input bit exp_match);
      int sb_shift[$];
      int sb_done[$];
      int d_cyc, n, k, last_busy;
      bit exp_en, exp_bit, exp_done, exp_busy, exp_m;
      logic [9:0] tmpw;
      logic o_en, o_bit, o_busy, o_done, o_match;
      logic [9:0] o_q;
      d_cyc = 3 + 9 * td;
      for (int i = 0; i < 10; i++)
         if (abort_at == 0 || (1 + i * td) <= abort_at) sb_shift.push_back(1 + i * td);
      if (abort_at == 0) sb_done.push_back(d_cyc);
      n = (abort_at == 0) ? d_cyc + 1 : abort_at + 4;
      last_busy = (abort_at == 0) ? d_cyc : abort_at;
      k = 0;
      if (sel) begin start1 = 1'b1; data1 = word; end
      else begin start0 = 1'b1; data0 = word; end
      for (int rel = 1; rel <= n; rel++) begin
         @(negedge clk);
         cur_rel = rel;
         exp_en = 1'b0;
         exp_bit = 1'b0;
         if (sb_shift.size() > 0 && sb_shift[0] == rel) begin
            void'(sb_shift.pop_front());
            exp_en = 1'b1;
            tmpw = word >> k;
            exp_bit = tmpw[0];
            k++;
         end
         exp_done = (sb_done.size() > 0 && sb_done[0] == rel);
         if (exp_done) void'(sb_done.pop_front());
         exp_busy = (rel <= last_busy);
         exp_m = (abort_at == 0 && rel >= d_cyc) ? exp_match : 1'b0;
         o_en    = sel ? shift_en1  : shift_en0;
         o_bit   = sel ? shift_bit1 : shift_bit0;
         o_busy  = sel ? busy1      : busy0;
         o_done  = sel ? done1      : done0;
         o_match = sel ? match1     : match0;
         o_q     = sel ? q1         : q0;
         chk("shift_en", 16'(o_en), 16'(exp_en));
         if (exp_en) chk("shift_bit", 16'(o_bit), 16'(exp_bit));
         chk("busy", 16'(o_busy), 16'(exp_busy));
         chk("done", 16'(o_done), 16'(exp_done));
         chk("match", 16'(o_match), 16'(exp_m));
         if (exp_en && !sel) mdl0 = {exp_bit, mdl0[9:1]};
         if (abort_at == 0 && rel == d_cyc - 1) chk("q_at_check", 16'(o_q), 16'(word));
         if (abort_at != 0 && rel == n && !sel) chk("q_after_abort", 16'(q0), 16'(mdl0));
         if (sel) begin
            start1 = 1'b0;
         end else begin
            start0     = busy_start && (rel == 20);
            abort0     = (abort_at != 0) && (rel == abort_at);
            man_pulse0 = noise && (rel < d_cyc - 1) && (rel % 2 == 1);
            man_bit0   = noise && (rel < d_cyc - 1);
         end
      end
   endtask

   initial begin
      n_cmp = 0; n_bad = 0; cur_rel = 0; mdl0 = '0; stuck = 1'b0;
      rst = 1'b1;
      start0 = 0; abort0 = 0; man_pulse0 = 0; man_bit0 = 0; data0 = '0;
      start1 = 0; abort1 = 0; man_pulse1 = 0; man_bit1 = 0; data1 = '0;
      repeat (2) @(negedge clk);
      chk("rst_shift_en", 16'(shift_en0), 16'd0);
      chk("rst_shift_bit", 16'(shift_bit0), 16'd0);
      chk("rst_busy", 16'(busy0), 16'd0);
      chk("rst_done", 16'(done0), 16'd0);
      chk("rst_match", 16'(match0), 16'd0);
      rst = 1'b0;
      @(negedge clk);

      // Default pace, with an ignored start while busy.
      run_load(1'b0, 10'h2B5, 4, 0, 1'b0, 1'b1, 1'b1);
      // Back-to-back start in the cycle after DONE, with manual pulses while busy.
      run_load(1'b0, 10'h0F3, 4, 0, 1'b1, 1'b0, 1'b1);

      // Manual path while idle: each pulse shifts a 1 into the MSB.
      for (int i = 0; i < 3; i++) begin
         man_bit0 = 1'b1;
         man_pulse0 = 1'b1;
         #1;
         chk("idle_pass_en", 16'(shift_en0), 16'd1);
         chk("idle_pass_bit", 16'(shift_bit0), 16'd1);
         mdl0 = {1'b1, mdl0[9:1]};
         @(negedge clk);
         man_pulse0 = 1'b0;
         man_bit0 = 1'b0;
         chk("manual_q", 16'(q0), 16'(mdl0));
         chk("manual_msb", 16'(q0[9]), 16'd1);
         @(negedge clk);
      end

      // Abort in cycle 10, then a normal load.
      run_load(1'b0, 10'h155, 4, 10, 1'b0, 1'b0, 1'b0);
      run_load(1'b0, 10'h2AA, 4, 0, 1'b0, 1'b0, 1'b1);

      // Reset asserted at cycle 20 of a load.
      cur_rel = 0;
      start0 = 1'b1;
      data0 = 10'h2B5;
      for (int rel = 1; rel <= 20; rel++) begin
         @(negedge clk);
         cur_rel = rel;
         start0 = 1'b0;
      end
      chk("busy_pre_rst", 16'(busy0), 16'd1);
      rst = 1'b1;
      #1;
      chk("rst_mid_busy", 16'(busy0), 16'd0);
      chk("rst_mid_shift_en", 16'(shift_en0), 16'd0);
      chk("rst_mid_done", 16'(done0), 16'd0);
      chk("rst_mid_match", 16'(match0), 16'd0);
      chk("rst_mid_q", 16'(q0), 16'd0);
      mdl0 = '0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_load(1'b0, 10'h001, 4, 0, 1'b0, 1'b0, 1'b1);

      // Readback with bit 0 stuck low must report a mismatch.
      stuck = 1'b1;
      run_load(1'b0, 10'h2B5, 4, 0, 1'b0, 1'b0, 1'b0);
      stuck = 1'b0;

      // Fastest pace: ten consecutive shifts.
      run_load(1'b1, 10'h3FF, 1, 0, 1'b0, 1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
